gray_stream_decoder: RTL and testbench



---
 rtl/gray_dec_pkg.sv | 29 ++
 rtl/gray2bin_pipe.sv | 27 ++
 rtl/gray_stream_decoder.sv | 185 ++++++++++++++++++
 tb/tb_gray_stream_decoder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_dec_pkg.sv
// Shared types and helpers for the Gray stream decoder.
// Helpers operate on zero-extended words up to GRAY_MAX_W bits wide.
package gray_dec_pkg;

  localparam int GRAY_MAX_W = 32;

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_e;
  typedef enum logic [1:0] {HOLD, UP, DOWN, ERR} step_e;

  function automatic int unsigned popcount(input logic [GRAY_MAX_W-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < GRAY_MAX_W; i++) begin
      cnt = cnt + 32'(v[i]);
    end
    return cnt;
  endfunction

  // Leading zeros from zero-extension leave the low bits of the prefix XOR unchanged.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_pipe.sv
// Registered Gray-to-binary converter, isolating the prefix-XOR chain
// in its own pipeline stage.
module gray2bin_pipe
  import gray_dec_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  logic [WIDTH-1:0] r_bin;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin <= '0;
    end else if (i_valid) begin
      r_bin <= WIDTH'(gray2bin(GRAY_MAX_W'(i_gray)));
    end
  end

  assign o_bin = r_bin;

endmodule

// File: rtl/gray_stream_decoder.sv
// Gray-coded stream decoder: two-stage pipeline converting samples to binary,
// classifying hold/up/down/multi-bit steps and tracking lock.
// Define GRAY_DEC_DIR_CHECK_EN to treat direction reversals while locked as errors.
module gray_stream_decoder
  import gray_dec_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int LOCK_CNT  = 3,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_gray,
  input  logic                 clear_err,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_bin,
  output logic                 out_up,
  output logic                 out_down,
  output logic                 err_multi_bit,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);

  logic              r_s1Valid;
  logic [WIDTH-1:0]  r_refGray;
  logic [1:0]        r_s1Ham;
  logic [1:0]        w_inHam;
  int unsigned       w_hamCount;
  logic [WIDTH-1:0]  w_s1Bin;
  logic [WIDTH-1:0]  w_refBinInc;
  state_e            r_state;
  state_e            w_stateNext;
  logic [GOOD_W-1:0] r_goodCnt;
  logic [GOOD_W-1:0] w_goodNext;
  step_e             w_step;
  logic              w_err;
`ifdef GRAY_DEC_DIR_CHECK_EN
  step_e             r_lastDir;
`endif

  // Distance class against the previous accepted sample: 0, 1 or 2 (meaning >1).
  always_comb begin
    w_hamCount = popcount(GRAY_MAX_W'(in_gray ^ r_refGray));
    if (w_hamCount == 0) begin
      w_inHam = 2'd0;
    end else if (w_hamCount == 1) begin
      w_inHam = 2'd1;
    end else begin
      w_inHam = 2'd2;
    end
  end

  // r_refGray is both the stage-1 sample register and the Gray reference.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1Valid <= 1'b0;
      r_refGray <= '0;
      r_s1Ham   <= 2'd0;
    end else begin
      r_s1Valid <= in_valid;
      if (in_valid) begin
        r_refGray <= in_gray;
        r_s1Ham   <= w_inHam;
      end
    end
  end

  gray2bin_pipe #(
    .WIDTH (WIDTH)
  ) u_gray2bin (
    .clk     (clk),
    .rst     (rst),
    .i_valid (in_valid),
    .i_gray  (in_gray),
    .o_bin   (w_s1Bin)
  );

  // out_bin always holds the binary of the previous accepted sample, so it is the binary reference.
  always_comb begin
    w_refBinInc = out_bin + WIDTH'(1);
    w_step      = HOLD;
    if (r_state != UNLOCKED) begin
      if (r_s1Ham == 2'd1) begin
        w_step = (w_s1Bin == w_refBinInc) ? UP : DOWN;
      end else if (r_s1Ham == 2'd2) begin
        w_step = ERR;
      end
`ifdef GRAY_DEC_DIR_CHECK_EN
      if ((r_state == LOCKED) &&
          (((w_step == UP) && (r_lastDir == DOWN)) ||
           ((w_step == DOWN) && (r_lastDir == UP)))) begin
        w_step = ERR;
      end
`endif
    end
    w_err = r_s1Valid && (w_step == ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= UNLOCKED;
      r_goodCnt <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_goodCnt <= w_goodNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_goodNext  = r_goodCnt;
    if (r_s1Valid) begin
      case (r_state)
        UNLOCKED: begin
          w_stateNext = ACQUIRE;
          w_goodNext  = '0;
        end
        ACQUIRE: begin
          if (w_step == ERR) begin
            w_stateNext = UNLOCKED;
            w_goodNext  = '0;
          end else if (r_goodCnt == GOOD_W'(LOCK_CNT - 1)) begin
            w_stateNext = LOCKED;
            w_goodNext  = GOOD_W'(LOCK_CNT);
          end else begin
            w_goodNext = r_goodCnt + GOOD_W'(1);
          end
        end
        LOCKED: begin
          if (w_step == ERR) begin
            w_stateNext = UNLOCKED;
            w_goodNext  = '0;
          end
        end
        default: begin
          w_stateNext = UNLOCKED;
          w_goodNext  = '0;
        end
      endcase
    end
  end

  always_comb begin
    locked = (r_state == LOCKED);
  end

  // Stage 2 outputs; clear_err wins over accumulation but still counts a coincident error.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_bin       <= '0;
      out_up        <= 1'b0;
      out_down      <= 1'b0;
      err_multi_bit <= 1'b0;
      err_count     <= '0;
    end else begin
      out_valid     <= r_s1Valid;
      out_up        <= r_s1Valid && (w_step == UP);
      out_down      <= r_s1Valid && (w_step == DOWN);
      err_multi_bit <= w_err;
      if (r_s1Valid) begin
        out_bin <= w_s1Bin;
      end
      if (clear_err) begin
        err_count <= ERR_CNT_W'(w_err);
      end else if (w_err && (err_count != '1)) begin
        err_count <= err_count + ERR_CNT_W'(1);
      end
    end
  end

`ifdef GRAY_DEC_DIR_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst || (w_stateNext == UNLOCKED)) begin
      r_lastDir <= HOLD;
    end else if (r_s1Valid && ((w_step == UP) || (w_step == DOWN))) begin
      r_lastDir <= w_step;
    end
  end
`endif

endmodule

// File: tb/tb_gray_stream_decoder.sv
// Self-checking bench for gray_stream_decoder (WIDTH=4, LOCK_CNT=3, ERR_CNT_W=2):
// directed scenarios then random traffic, compared against a behavioural model.
module tb_gray_stream_decoder;

  localparam int W         = 4;
  localparam int N         = 16;
  localparam int LOCK_CNT  = 3;
  localparam int ERR_CNT_W = 2;
  localparam int ERR_MAX   = 3;
  localparam int M_UNL     = 0;
  localparam int M_ACQ     = 1;
  localparam int M_LOCK    = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic [W-1:0]         in_gray;
  logic                 clear_err;
  logic                 out_valid;
  logic [W-1:0]         out_bin;
  logic                 out_up;
  logic                 out_down;
  logic                 err_multi_bit;
  logic                 locked;
  logic [ERR_CNT_W-1:0] err_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit       pendV;
  logic [W-1:0] pendG;
  logic [W-1:0] refG;
  int       refBin;
  int       mState;
  int       good;
  int       lastDir;
  int       errCnt;
  bit       expValid;
  bit       expUp;
  bit       expDown;
  bit       expErr;
  bit       expLocked;
  int       expBin;
  logic [W-1:0] lastG;

  gray_stream_decoder #(
    .WIDTH     (W),
    .LOCK_CNT  (LOCK_CNT),
    .ERR_CNT_W (ERR_CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_gray       (in_gray),
    .clear_err     (clear_err),
    .out_valid     (out_valid),
    .out_bin       (out_bin),
    .out_up        (out_up),
    .out_down      (out_down),
    .err_multi_bit (err_multi_bit),
    .locked        (locked),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  function automatic int grayToBin(input logic [W-1:0] g);
    for (int v = 0; v < N; v++) begin
      if (W'(v ^ (v >> 1)) == g) return v;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] binToGray(input int b);
    return W'(b ^ (b >> 1));
  endfunction

  // Model of one clock edge: the sample accepted on the previous edge emerges now.
  task automatic modelEdge(input bit r, input bit v, input logic [W-1:0] g, input bit clr);
    int bin;
    int ham;
    int kind;
    if (r) begin
      pendV = 1'b0; pendG = '0; refG = '0; refBin = 0;
      mState = M_UNL; good = 0; lastDir = 0; errCnt = 0;
      expValid = 1'b0; expBin = 0; expUp = 1'b0; expDown = 1'b0; expErr = 1'b0;
    end else begin
      expValid = pendV;
      expUp = 1'b0; expDown = 1'b0; expErr = 1'b0;
      if (pendV) begin
        bin = grayToBin(pendG);
        ham = $countones(pendG ^ refG);
        if (mState == M_UNL) begin
          mState = M_ACQ;
          good   = 0;
        end else begin
          if (ham == 0) kind = 0;
          else if (ham == 1) kind = (bin == (refBin + 1) % N) ? 1 : 2;
          else kind = 3;
`ifdef GRAY_DEC_DIR_CHECK_EN
          if (mState == M_LOCK && (kind == 1 || kind == 2) && lastDir != 0 && kind != lastDir) kind = 3;
`endif
          if (kind == 3) begin
            expErr = 1'b1;
            mState = M_UNL;
          end else begin
            expUp   = (kind == 1);
            expDown = (kind == 2);
            if (kind != 0) lastDir = kind;
            if (mState == M_ACQ) begin
              good++;
              if (good >= LOCK_CNT) mState = M_LOCK;
            end
          end
        end
        if (mState == M_UNL) lastDir = 0;
        refG   = pendG;
        refBin = bin;
        expBin = bin;
      end
      if (clr) errCnt = expErr ? 1 : 0;
      else if (expErr && errCnt < ERR_MAX) errCnt++;
      pendV = v;
      pendG = g;
    end
    expLocked = (mState == M_LOCK);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit v, input logic [W-1:0] g, input bit clr);
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    in_gray   = g;
    clear_err = clr;
    @(posedge clk);
    modelEdge(r, v, g, clr);
    #1;
    checkOutput("out_valid", 32'(out_valid), 32'(expValid));
    if (expValid || r) checkOutput("out_bin", 32'(out_bin), 32'(expBin));
    checkOutput("out_up", 32'(out_up), 32'(expUp));
    checkOutput("out_down", 32'(out_down), 32'(expDown));
    checkOutput("err_multi_bit", 32'(err_multi_bit), 32'(expErr));
    checkOutput("locked", 32'(locked), 32'(expLocked));
    checkOutput("err_count", 32'(err_count), 32'(errCnt));
    if (r) lastG = '0;
    else if (v) lastG = g;
  endtask

  task automatic sendGray(input logic [W-1:0] g);
    applyStimulus(1'b0, 1'b1, g, 1'b0);
  endtask

  task automatic sendBin(input int b);
    applyStimulus(1'b0, 1'b1, binToGray(b), 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    bit           r;
    bit           v;
    bit           clr;
    int           sel;
    int           cur;
    logic [W-1:0] g;

    rst = 1'b1; in_valid = 1'b0; in_gray = '0; clear_err = 1'b0; lastG = '0;

    $display("[TB] reset state");
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);

    $display("[TB] count-up sweep and wrap");
    sendGray(4'b0000); sendGray(4'b0001); sendGray(4'b0011); sendGray(4'b0010); sendGray(4'b0110);
    for (int b = 5; b < N; b++) sendBin(b);
    sendBin(0);
    sendBin(15);

    $display("[TB] illegal jump and relock");
    sendBin(0); sendBin(1); sendBin(2);
    sendGray(4'b0110);
    for (int b = 5; b < 10; b++) sendBin(b);
    idle(3);

    $display("[TB] error counter saturation and clear");
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    for (int k = 0; k < 10; k++) sendGray((k % 2 == 1) ? 4'b0101 : 4'b0000);
    sendGray(4'b0000);
    sendGray(4'b0101);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    idle(1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);

    $display("[TB] gaps and hold");
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    sendGray(4'b0001);
    idle(2);
    sendGray(4'b0001);
    idle(3);

    $display("[TB] mid-stream reset");
    sendGray(4'b0011);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    idle(3);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(63) == 0);
      v   = ($urandom_range(3) != 0) && !r;
      clr = ($urandom_range(15) == 0);
      sel = $urandom_range(9);
      cur = grayToBin(lastG);
      if (sel < 3) begin
        g = lastG;
      end else if (sel < 6) begin
        g = binToGray((cur + 1) % N);
      end else if (sel < 9) begin
        g = binToGray((cur + N - 1) % N);
      end else begin
        g = W'($urandom_range(N - 1));
        while ($countones(g ^ lastG) < 2) g = W'($urandom_range(N - 1));
      end
      applyStimulus(r, v, g, clr);
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
